pipeline_exec_ctrl: RTL

Execution controller for the 5-stage MIPS pipeline. It sequences the whole datapath under command control: free-run, single-step, pause and restart. When a HALT instruction reaches ID it drains the instructions already in flight, then freezes the pipeline. It sits between the debug/command front end and the pipeline. Its enables are ANDed with the hazard unit's PCWrite/IFIDWrite stall signals, so hazard stalls still work inside a run or step.

---
 rtl/pipeline_exec_ctrl.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/pipeline_exec_ctrl.sv
// Execution controller for the 5-stage MIPS pipeline: run/step/pause/restart
// sequencing, HALT drain, and an executed-cycle counter. All outputs are registered.
module pipeline_exec_ctrl #(
   parameter int CNT_W        = 32,
   parameter int DRAIN_CYCLES = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   input  logic [1:0]       cmd,
   output logic             cmd_ready,
   input  logic             halt_id,
   output logic             pipe_en,
   output logic             pc_write_en,
   output logic             ifid_flush,
   output logic             pc_clear,
   output logic             done,
   output logic [CNT_W-1:0] cycle_count,
   output logic [2:0]       state
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RUN   = 3'd1,
      ST_STEP  = 3'd2,
      ST_DRAIN = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   typedef enum logic [1:0] {
      CMD_RUN     = 2'b00,
      CMD_STEP    = 2'b01,
      CMD_PAUSE   = 2'b10,
      CMD_RESTART = 2'b11
   } cmd_t;

   localparam logic [3:0]       DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX    = '1;
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

   state_t           state_q, state_d;
   logic [3:0]       drain_cnt_q, drain_cnt_d;
   logic             cmd_ready_q, cmd_ready_d;
   logic             pipe_en_q, pipe_en_d;
   logic             pc_write_en_q, pc_write_en_d;
   logic             ifid_flush_q, ifid_flush_d;
   logic             pc_clear_q, pc_clear_d;
   logic             done_q, done_d;
   logic [CNT_W-1:0] cycle_count_q, cycle_count_d;

   logic cmd_acc;
   cmd_t cmd_e;

   assign cmd_acc = cmd_valid && cmd_ready_q;
   assign cmd_e   = cmd_t'(cmd);

   // Next-state logic. RESTART outranks halt_id, which outranks PAUSE.
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
      state_d     = state_q;
      drain_cnt_d = drain_cnt_q;
      pc_clear_d  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (cmd_acc) begin
               case (cmd_e)
                  CMD_RUN:     state_d    = ST_RUN;
                  CMD_STEP:    state_d    = ST_STEP;
                  CMD_RESTART: pc_clear_d = 1'b1;
                  default:     state_d    = ST_IDLE;
               endcase
            end
         end

         ST_RUN: begin
            if (cmd_acc && cmd_e == CMD_RESTART) begin
               state_d    = ST_IDLE;
               pc_clear_d = 1'b1;
            end else if (halt_id) begin
               state_d     = ST_DRAIN;
               drain_cnt_d = DRAIN_LOAD;
            end else if (cmd_acc && cmd_e == CMD_PAUSE) begin
               state_d = ST_IDLE;
            end
         end

         ST_STEP: begin
            if (halt_id) begin
               state_d     = ST_DRAIN;
               drain_cnt_d = DRAIN_LOAD;
            end else begin
               state_d = ST_IDLE;
            end
         end

         ST_DRAIN: begin
            if (drain_cnt_q == 4'd0) begin
               state_d = ST_DONE;
            end else begin
               drain_cnt_d = drain_cnt_q - 4'd1;
            end
         end

         ST_DONE: begin
            if (cmd_acc && cmd_e == CMD_RESTART) begin
               state_d    = ST_IDLE;
               pc_clear_d = 1'b1;
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   // Registered outputs are decoded from the state being entered.
   always_comb begin
      pipe_en_d     = (state_d == ST_RUN) || (state_d == ST_STEP) || (state_d == ST_DRAIN);
      pc_write_en_d = (state_d == ST_RUN) || (state_d == ST_STEP);
      ifid_flush_d  = (state_d == ST_DRAIN);
      done_d        = (state_d == ST_DONE);
      cmd_ready_d   = (state_d == ST_IDLE) || (state_d == ST_RUN) || (state_d == ST_DONE);
   end

   // Counts edges that close an enabled cycle; the pc_clear cycle zeroes it.
   always_comb begin
      cycle_count_d = cycle_count_q;
      if (pc_clear_q) begin
         cycle_count_d = '0;
      end else if (pipe_en_q && cycle_count_q != CNT_MAX) begin
         cycle_count_d = cycle_count_q + CNT_ONE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         drain_cnt_q   <= 4'd0;
         cmd_ready_q   <= 1'b1;
         pipe_en_q     <= 1'b0;
         pc_write_en_q <= 1'b0;
         ifid_flush_q  <= 1'b0;
         pc_clear_q    <= 1'b0;
         done_q        <= 1'b0;
         cycle_count_q <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state_q       <= state_d;
         drain_cnt_q   <= drain_cnt_d;
         cmd_ready_q   <= cmd_ready_d;
         pipe_en_q     <= pipe_en_d;
         pc_write_en_q <= pc_write_en_d;
         ifid_flush_q  <= ifid_flush_d;
         pc_clear_q    <= pc_clear_d;
         done_q        <= done_d;
         cycle_count_q <= cycle_count_d;
      end
   end

   assign state       = state_q;
   assign cmd_ready   = cmd_ready_q;
   assign pipe_en     = pipe_en_q;
   assign pc_write_en = pc_write_en_q;
   assign ifid_flush  = ifid_flush_q;
   assign pc_clear    = pc_clear_q;
   assign done        = done_q;
   assign cycle_count = cycle_count_q;

   a_clear_idle: assert property (@(posedge clk) disable iff (!rst_n) pc_clear_q |-> !pipe_en_q);
   a_done_idle:  assert property (@(posedge clk) disable iff (!rst_n) done_q |-> !pipe_en_q);
   a_flush_only_drain: assert property (@(posedge clk) disable iff (!rst_n)
                                        ifid_flush_q |-> (state_q == ST_DRAIN && !pc_write_en_q));

endmodule
